uart_tx: RTL and testbench

8N1 UART transmitter. It is the transmit-side counterpart of uart_rx and drives the serial line that uart_rx samples, both in the board link and in the loopback bench. It accepts one byte per valid/ready handshake and serializes it as start bit, 8 data bits LSB-first, then stop bit. Its default bit timing matches the uart_rx bit period on the 50 MHz system clock.

---
 rtl/uart_tx.sv | 153 +++++++++++++++
 tb/tb_uart_tx.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- 8N1 UART transmitter
//
// Serializes one byte per handshake as: start bit (0), 8 data bits LSB first,
// stop bit (1). Each bit is held for CLKS_PER_BIT clock cycles. The serial line
// comes straight from a flop, so it never glitches.
//
// Handshake: a byte is accepted on a rising edge of uart_clock where
// uart_d_valid=1 and uart_ready=1. uart_ready is high only in IDLE. uart_d_in
// is sampled on that edge alone. Valid asserted while a frame is in flight is
// ignored and is not queued.
//
// Ports:
//   uart_clock    in   system clock, rising-edge active
//   uart_reset    in   asynchronous active-low reset
//   uart_d_in     in   byte to transmit (sampled only on accept)
//   uart_d_valid  in   uart_d_in holds a valid byte
//   uart_ready    out  transmitter can accept a byte this cycle
//   uart_tx_out   out  serial line, idle high
//   uart_busy     out  frame in progress
//   uart_done     out  one-cycle pulse in the first IDLE cycle after stop bit
//   uart_state    out  current FSM state (IDLE=0, START=1, DATA=2, STOP=3)
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int CLKS_PER_BIT = 108,
    parameter int DATA_BITS    = 8
) (
    input  logic       uart_clock,
    input  logic       uart_reset,
    input  logic [7:0] uart_d_in,
    input  logic       uart_d_valid,
    output logic       uart_ready,
    output logic       uart_tx_out,
    output logic       uart_busy,
    output logic       uart_done,
    output logic [1:0] uart_state
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_cpb
            $error("uart_tx: CLKS_PER_BIT must be >= 2");
        end
        if (DATA_BITS != 8) begin : g_bad_bits
            $error("uart_tx: DATA_BITS is fixed at 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0]       idx, idx_nx;
    logic [7:0]       shreg, shreg_nx;
    logic             tx_nx;
    logic             done_nx;
    logic             bit_end;

    assign bit_end    = (cnt == CNT_LAST);
    assign uart_ready = (state == IDLE);
    assign uart_busy  = (state != IDLE);
    assign uart_state = state;

    always_ff @(posedge uart_clock or negedge uart_reset) begin
        if (!uart_reset) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            uart_tx_out <= 1'b1;
            uart_done   <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            idx         <= idx_nx;
            shreg       <= shreg_nx;
            uart_tx_out <= tx_nx;
            uart_done   <= done_nx;
        end
    end

    // The line value is computed one cycle ahead for the state being entered,
    // so the registered output lines up exactly with the state it belongs to.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        shreg_nx = shreg;
        tx_nx    = uart_tx_out;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                idx_nx = '0;
                tx_nx  = 1'b1;
                if (uart_d_valid) begin
                    shreg_nx = uart_d_in;
                    state_nx = START;
                    tx_nx    = 1'b0;
                end
            end
            START: begin
                tx_nx = 1'b0;
                if (bit_end) begin
                    cnt_nx   = '0;
                    state_nx = DATA;
                    tx_nx    = shreg[0];
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_nx   = '0;
                    shreg_nx = {1'b0, shreg[7:1]};
                    if (idx == IDX_LAST) begin
                        state_nx = STOP;
                        tx_nx    = 1'b1;
                    end else begin
                        idx_nx = idx + 3'd1;
                        // Next bit is the one about to shift into position 0.
                        tx_nx  = shreg[1];
                    end
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                tx_nx = 1'b1;
                if (bit_end) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                tx_nx    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx -- self-checking bench for uart_tx (CLKS_PER_BIT = 108, 50 MHz)
//
// The reference model describes the line by position inside a frame: once a
// byte is accepted, cycle p of the frame carries bit p/CPB of
// {stop, data, start}. A serial decoder samples the line at mid-bit and checks
// the recovered bytes against the queue of accepted bytes.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int CPB   = 108;
    localparam int FRAME = 10 * CPB;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       d_valid = 1'b0;
    logic [7:0] d_in = 8'h00;
    logic       ready, tx, busy, done;
    logic [1:0] dbg_state;

    always #10 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .uart_clock   (clk),
        .uart_reset   (rst_n),
        .uart_d_in    (d_in),
        .uart_d_valid (d_valid),
        .uart_ready   (ready),
        .uart_tx_out  (tx),
        .uart_busy    (busy),
        .uart_done    (done),
        .uart_state   (dbg_state)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    // ---------------- reference model ----------------
    bit         m_active = 1'b0;
    int         m_pos    = 0;
    logic [9:0] m_frame  = 10'h3ff;
    bit         m_done   = 1'b0;
    logic [7:0] exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_pos    = 0;
            m_done   = 1'b0;
            exp_q.delete();
        end else begin
            m_done = 1'b0;
            if (m_active) begin
                if (m_pos == FRAME - 1) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end else begin
                    m_pos++;
                end
            end else if (d_valid) begin
                m_active = 1'b1;
                m_pos    = 0;
                m_frame  = {1'b1, d_in, 1'b0};
                exp_q.push_back(d_in);
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("tx",    {31'd0, tx},    {31'd0, (m_active ? m_frame[m_pos / CPB] : 1'b1)});
        chk("ready", {31'd0, ready}, {31'd0, !m_active});
        chk("busy",  {31'd0, busy},  {31'd0, m_active});
        chk("done",  {31'd0, done},  {31'd0, m_done});
    end

    // ---------------- serial decoder / scoreboard ----------------
    bit         rx_on   = 1'b0;
    int         rx_k    = 0;
    logic       rx_prev = 1'b1;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] rx_log[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            rx_on   = 1'b0;
            rx_prev = 1'b1;
        end else begin
            if (!rx_on && rx_prev === 1'b1 && tx === 1'b0) begin
                rx_on = 1'b1;
                rx_k  = 0;
            end
            if (rx_on) begin
                if (rx_k % CPB == CPB / 2) begin
                    if (rx_k / CPB == 0) begin
                        chk("rx_start", {31'd0, tx}, 32'd0);
                    end else if (rx_k / CPB <= 8) begin
                        rx_byte[rx_k / CPB - 1] = tx;
                    end else begin
                        chk("rx_stop", {31'd0, tx}, 32'd1);
                        if (exp_q.size() == 0) begin
                            timeout_fail("rx_unexpected_byte");
                        end else begin
                            chk("rx_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
                        end
                        rx_log.push_back(rx_byte);
                        rx_on = 1'b0;
                    end
                end
                rx_k++;
            end
            rx_prev = tx;
        end
    end

    // ---------------- driver tasks ----------------
    logic samp[0:2999];
    int   done_cnt;
    int   done_at;
    logic rdy_at_done;

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) timeout_fail("wait_ready");
    endtask

    // Returns just after the accept edge; the next negedge is the first
    // start-bit cycle. uart_d_in is scrambled afterwards on purpose.
    task automatic send_byte(input logic [7:0] b);
        wait_ready();
        d_valid = 1'b1;
        d_in    = b;
        @(posedge clk);
        #1;
        d_valid = 1'b0;
        d_in    = 8'($urandom);
    endtask

    task automatic capture(input int n, input int v_on, input int v_off, input logic [7:0] vb);
        done_cnt    = 0;
        done_at     = -1;
        rdy_at_done = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            samp[k] = tx;
            if (done === 1'b1) begin
                done_cnt++;
                done_at     = k;
                rdy_at_done = ready;
            end
            if (k == v_on) begin
                d_valid = 1'b1;
                d_in    = vb;
            end
            if (k == v_off) d_valid = 1'b0;
        end
    endtask

    // f[b] is the line value of bit slot b in time order (slot 0 = start).
    task automatic check_frame(input string nm, input int base, input logic [9:0] f);
        for (int b = 0; b < 10; b++) begin
            chk($sformatf("%s_bit%0d_first", nm, b), {31'd0, samp[base + b * CPB]}, {31'd0, f[b]});
            chk($sformatf("%s_bit%0d_last", nm, b), {31'd0, samp[base + b * CPB + CPB - 1]}, {31'd0, f[b]});
        end
    endtask

    function automatic int count_low(input int from, input int to);
        int c = 0;
        for (int k = from; k < to; k++) if (samp[k] !== 1'b1) c++;
        return c;
    endfunction

    // ---------------- test sequence ----------------
    logic [7:0] eled[4] = '{8'h45, 8'h4C, 8'h45, 8'h44};
    int         fe[$];
    logic       prev;

    initial begin
        // Reset held for 50 us.
        #2 rst_n = 1'b0;
        #1000;
        chk("rst_tx",    {31'd0, tx},    32'd1);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_busy",  {31'd0, busy},  32'd0);
        chk("rst_done",  {31'd0, done},  32'd0);
        #49000;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_tx",    {31'd0, tx},    32'd1);
        chk("post_rst_ready", {31'd0, ready}, 32'd1);
        chk("post_rst_busy",  {31'd0, busy},  32'd0);
        chk("post_rst_done",  {31'd0, done},  32'd0);

        // Single byte 'E'.
        send_byte(8'h45);
        capture(1150, -1, -1, 8'h00);
        check_frame("e", 0, 10'b1010001010);
        chk("e_done_cnt",   done_cnt,    1);
        chk("e_done_at",    done_at,     1080);
        chk("e_done_ready", {31'd0, rdy_at_done}, 32'd1);
        chk("e_idle_after", count_low(1080, 1150), 0);

        // "ELED" with 100 us gaps.
        rx_log.delete();
        for (int i = 0; i < 4; i++) begin
            send_byte(eled[i]);
            repeat (5000) @(negedge clk);
        end
        chk("eled_count", rx_log.size(), 4);
        if (rx_log.size() == 4) begin
            chk("eled_0", {24'd0, rx_log[0]}, 32'h45);
            chk("eled_1", {24'd0, rx_log[1]}, 32'h4C);
            chk("eled_2", {24'd0, rx_log[2]}, 32'h45);
            chk("eled_3", {24'd0, rx_log[3]}, 32'h44);
        end

        // Back-to-back 0x00 then 0xFF with valid held high.
        wait_ready();
        d_valid = 1'b1;
        d_in    = 8'h00;
        @(posedge clk);
        #1 d_in = 8'hFF;
        capture(2300, -1, 1081, 8'h00);
        fe.delete();
        prev = 1'b1;
        for (int k = 0; k < 2300; k++) begin
            if (prev === 1'b1 && samp[k] === 1'b0) fe.push_back(k);
            prev = samp[k];
        end
        chk("b2b_edges", fe.size(), 2);
        if (fe.size() == 2) begin
            chk("b2b_first_edge", fe[0], 0);
            chk("b2b_period", fe[1] - fe[0], 1081);
        end
        check_frame("b2b0", 0, 10'b1000000000);
        check_frame("b2b1", 1081, 10'b1111111110);
        chk("b2b_gap_high", {31'd0, samp[1080]}, 32'd1);
        chk("b2b_done_cnt", done_cnt, 2);

        // Valid with 0xAA during the DATA phase of 0x55.
        send_byte(8'h55);
        capture(1500, 3 * CPB, 3 * CPB + 20, 8'hAA);
        check_frame("busy", 0, 10'b1010101010);
        chk("busy_done_cnt", done_cnt, 1);
        chk("busy_no_extra", count_low(1080, 1500), 0);

        // Reset during data bit 3 of 0x45, then 0x4C.
        send_byte(8'h45);
        repeat (4 * CPB + 50) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_tx",    {31'd0, tx},    32'd1);
        chk("mid_rst_ready", {31'd0, ready}, 32'd1);
        chk("mid_rst_busy",  {31'd0, busy},  32'd0);
        chk("mid_rst_done",  {31'd0, done},  32'd0);
        capture(200, -1, -1, 8'h00);
        rst_n = 1'b1;
        chk("mid_rst_no_done", done_cnt, 0);
        chk("mid_rst_line_high", count_low(0, 200), 0);
        capture(1200, -1, -1, 8'h00);
        chk("mid_rst_no_done_after", done_cnt, 0);
        send_byte(8'h4C);
        capture(1150, -1, -1, 8'h00);
        check_frame("l", 0, 10'b1010011000);
        chk("l_done_cnt", done_cnt, 1);
        chk("l_done_at",  done_at,  1080);

        // Randomized traffic: random bytes, gaps and valid hold lengths, with
        // uart_d_in churning every cycle while valid is high.
        for (int it = 0; it < 15; it++) begin
            repeat ($urandom_range(0, 200)) @(negedge clk);
            for (int h = $urandom_range(1, 1400); h > 0; h--) begin
                @(negedge clk);
                d_valid = 1'b1;
                d_in    = 8'($urandom);
            end
            @(negedge clk);
            d_valid = 1'b0;
        end
        repeat (FRAME + 200) @(negedge clk);
        chk("drain_exp_q", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
